roi_band_centroid: RTL

ROI_BAND_CENTROID -- requirements
Module: roi_band_centroid

---
 rtl/roi_band_centroid.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/roi_band_centroid.sv
// roi_band_centroid: per-band lit-pixel column centroid with a serial restoring divider.
// Define ROI_CENTROID_ROUND_EN for round-to-nearest with saturation at IMG_W-1.
module roi_band_centroid #(
  parameter int IMG_W     = 640,
  parameter int IMG_H     = 480,
  parameter int PIX_W     = 4,
  parameter int NUM_BANDS = 2,
  parameter int BAND_H    = 32,
  parameter int THRESHOLD = 0,
  parameter int MIN_PIX   = 1,
  localparam int XW   = $clog2(IMG_W),
  localparam int CNTW = $clog2(IMG_W*BAND_H+1),
  localparam int BW   = NUM_BANDS > 1 ? $clog2(NUM_BANDS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pix_valid_i,
  input  logic [PIX_W-1:0] pix_data_i,
  input  logic             sof_i,
  input  logic             res_ready_i,
  output logic             res_valid_o,
  output logic [BW-1:0]    res_band_o,
  output logic [XW-1:0]    res_x_o,
  output logic [CNTW-1:0]  res_count_o,
  output logic             res_lost_o,
  output logic             overrun_o
);
  localparam int YW  = $clog2(IMG_H);
  localparam int SW  = XW + CNTW;
  localparam int SCW = $clog2(XW) + 1;
  localparam logic [XW-1:0] XMAX = XW'(IMG_W-1);
  localparam logic [YW-1:0] YMAX = YW'(IMG_H-1);

  typedef enum logic [1:0] {IDLE, LOAD, DIV, OUT} state_t;

  state_t           state_q;
  logic [XW-1:0]    x_q, ex;
  logic [YW-1:0]    y_q, ey;
  logic [SW-1:0]    acc_sum_q [NUM_BANDS];
  logic [SW-1:0]    snap_sum_q [NUM_BANDS];
  logic [SW-1:0]    sum_d [NUM_BANDS];
  logic [CNTW-1:0]  acc_cnt_q [NUM_BANDS];
  logic [CNTW-1:0]  snap_cnt_q [NUM_BANDS];
  logic [CNTW-1:0]  cnt_d [NUM_BANDS];
  logic [NUM_BANDS-1:0] hit;
  logic             fe;
  logic [BW-1:0]    band_q;
  logic [CNTW-1:0]  rem_q, rem_d, cur_cnt;
  logic [XW-1:0]    nlo_q, q_d, x_res;
  logic [SCW-1:0]   step_q;
  logic [SW-1:0]    num;
  logic [CNTW:0]    trial;
  logic             ge;
  logic             res_valid_q, res_lost_q, overrun_q;
  logic [BW-1:0]    res_band_q;
  logic [XW-1:0]    res_x_q;
  logic [CNTW-1:0]  res_count_q;

  // sof relocates the current pixel to (0,0) and discards partial sums before it is added
  always_comb begin
    ex = sof_i ? '0 : x_q;
    ey = sof_i ? '0 : y_q;
    fe = pix_valid_i && ex == XMAX && ey == YMAX;
    hit = '0;
    for (int b = 0; b < NUM_BANDS; b++) begin
      hit[b] = pix_data_i > PIX_W'(THRESHOLD) && int'(ey) >= IMG_H-(b+1)*BAND_H && int'(ey) < IMG_H-b*BAND_H;
      sum_d[b] = (sof_i ? '0 : acc_sum_q[b]) + (hit[b] ? SW'(ex) : '0);
      cnt_d[b] = (sof_i ? '0 : acc_cnt_q[b]) + CNTW'(hit[b]);
    end
  end

  always_comb begin
    cur_cnt = snap_cnt_q[band_q];
`ifdef ROI_CENTROID_ROUND_EN
    num = snap_sum_q[band_q] + SW'(cur_cnt >> 1);
`else
    num = snap_sum_q[band_q];
`endif
    trial = {rem_q, nlo_q[XW-1]};
    ge = trial >= {1'b0, cur_cnt};
    rem_d = ge ? CNTW'(trial - {1'b0, cur_cnt}) : trial[CNTW-1:0];
    q_d = {nlo_q[XW-2:0], ge};
`ifdef ROI_CENTROID_ROUND_EN
    x_res = q_d > XMAX ? XMAX : q_d;
`else
    x_res = q_d;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q <= '0;
      y_q <= '0;
      for (int b = 0; b < NUM_BANDS; b++) begin
        acc_sum_q[b] <= '0;
        acc_cnt_q[b] <= '0;
        snap_sum_q[b] <= '0;
        snap_cnt_q[b] <= '0;
      end
    end else if (pix_valid_i) begin
      x_q <= ex == XMAX ? '0 : ex + 1'b1;
      y_q <= ex != XMAX ? ey : ey == YMAX ? '0 : ey + 1'b1;
      for (int b = 0; b < NUM_BANDS; b++) begin
        acc_sum_q[b] <= fe ? '0 : sum_d[b];
        acc_cnt_q[b] <= fe ? '0 : cnt_d[b];
        if (fe && state_q == IDLE) begin
          snap_sum_q[b] <= sum_d[b];
          snap_cnt_q[b] <= cnt_d[b];
        end
      end
    end
  end

  // the low XW numerator bits shift out MSB first while quotient bits shift in behind them
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      band_q <= '0;
      rem_q <= '0;
      nlo_q <= '0;
      step_q <= '0;
      res_valid_q <= 1'b0;
      res_band_q <= '0;
      res_x_q <= '0;
      res_count_q <= '0;
      res_lost_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= fe && state_q != IDLE;
      case (state_q)
        IDLE: if (fe) begin
          state_q <= LOAD;
          band_q <= '0;
        end
        LOAD: begin
          res_band_q <= band_q;
          res_count_q <= cur_cnt;
          step_q <= '0;
          if (cur_cnt < CNTW'(MIN_PIX)) begin
            res_lost_q <= 1'b1;
            res_x_q <= '0;
            res_valid_q <= 1'b1;
            state_q <= OUT;
          end else begin
            res_lost_q <= 1'b0;
            rem_q <= num[SW-1:XW];
            nlo_q <= num[XW-1:0];
            state_q <= DIV;
          end
        end
        DIV: begin
          rem_q <= rem_d;
          nlo_q <= q_d;
          step_q <= step_q + 1'b1;
          if (step_q == SCW'(XW-1)) begin
            res_x_q <= x_res;
            res_valid_q <= 1'b1;
            state_q <= OUT;
          end
        end
        default: if (res_ready_i) begin
          res_valid_q <= 1'b0;
          band_q <= band_q + 1'b1;
          state_q <= band_q == BW'(NUM_BANDS-1) ? IDLE : LOAD;
        end
      endcase
    end
  end

  assign res_valid_o = res_valid_q;
  assign res_band_o  = res_band_q;
  assign res_x_o     = res_x_q;
  assign res_count_o = res_count_q;
  assign res_lost_o  = res_lost_q;
  assign overrun_o   = overrun_q;
endmodule
